// File: rtl/aes_decipher_ctrl.sv
// Round sequencer for the combinational AES decipher datapath: owns the 128-bit
// working state, steps INIT -> MAIN x(nr-1) -> FINAL and publishes the result.
module aes_decipher_ctrl #(
  parameter int AES128_ROUNDS = 10,
  parameter int AES256_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic         ready,
  output logic [127:0] result,
  output logic         result_valid,
  output logic [3:0]   round_nr,
  output logic [1:0]   round_type,
  output logic [127:0] dp_state,
  input  logic [127:0] dp_new_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    MAIN  = 2'd2,
    FINAL = 2'd3
  } fsm_t;

  localparam logic [3:0] NR_128 = 4'(AES128_ROUNDS);
  localparam logic [3:0] NR_256 = 4'(AES256_ROUNDS);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] result_q, result_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   nr_q, nr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      round_q  <= '0;
      nr_q     <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      round_q  <= round_d;
      nr_q     <= nr_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    result_d = result_q;
    valid_d  = valid_q;
    ready_d  = ready_q;
    round_d  = round_q;
    nr_d     = nr_q;
    case (fsm_q)
      IDLE: begin
        // The datapath output is ignored here; only a start touches state.
        if (next) begin
          state_d = block;
          nr_d    = keylen ? NR_256 : NR_128;
          round_d = nr_d;
          valid_d = 1'b0;
          ready_d = 1'b0;
          fsm_d   = INIT;
        end
      end
      INIT: begin
        state_d = dp_new_state;
        round_d = nr_q - 4'd1;
        fsm_d   = MAIN;
      end
      MAIN: begin
        state_d = dp_new_state;
        if (round_q == 4'd1) begin
          round_d = 4'd0;
          fsm_d   = FINAL;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      FINAL: begin
        state_d  = dp_new_state;
        result_d = dp_new_state;
        valid_d  = 1'b1;
        ready_d  = 1'b1;
        round_d  = 4'd0;
        fsm_d    = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath round select is a pure decode of the state register.
  always_comb begin
    round_type = 2'd3;
    case (fsm_q)
      INIT:    round_type = 2'd0;
      MAIN:    round_type = 2'd1;
      FINAL:   round_type = 2'd2;
      default: round_type = 2'd3;
    endcase
  end

  assign ready        = ready_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign round_nr     = round_q;
  assign dp_state     = state_q;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Bench for aes_decipher_ctrl with a +1 stub datapath and a cycle-level
// behavioural model (start time, round index k, expected result = block+nr+1).
module tb_aes_decipher_ctrl;

  logic         clk;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [127:0] block;
  logic         ready;
  logic [127:0] result;
  logic         result_valid;
  logic [3:0]   round_nr;
  logic [1:0]   round_type;
  logic [127:0] dp_state;
  logic [127:0] dp_new_state;

  aes_decipher_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .next         (next),
    .keylen       (keylen),
    .block        (block),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid),
    .round_nr     (round_nr),
    .round_type   (round_type),
    .dp_state     (dp_state),
    .dp_new_state (dp_new_state)
  );

  assign dp_new_state = dp_state + 128'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Model: busy flag, round index k within the run (0 = INIT .. nr = FINAL).
  bit           m_busy;
  int           m_k;
  int           m_nr;
  logic [127:0] m_block;
  logic [127:0] m_result;
  logic         m_valid;
  logic [127:0] m_idle_state;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_round_type();
    if (!m_busy) return 2'd3;
    if (m_k == 0) return 2'd0;
    if (m_k == m_nr) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [3:0] exp_round_nr();
    if (!m_busy) return 4'd0;
    if (m_k == 0) return 4'(m_nr);
    return 4'(m_nr - m_k);
  endfunction

  function automatic logic [127:0] exp_dp_state();
    if (!m_busy) return m_idle_state;
    return m_block + 128'(m_k);
  endfunction

  task automatic model_step();
    if (!reset_n) begin
      m_busy = 0; m_k = 0; m_nr = 0; m_block = '0;
      m_result = '0; m_valid = 0; m_idle_state = '0;
    end else if (!m_busy) begin
      if (next) begin
        m_busy  = 1;
        m_k     = 0;
        m_nr    = keylen ? 14 : 10;
        m_block = block;
        m_valid = 0;
      end
    end else if (m_k == m_nr) begin
      m_busy       = 0;
      m_result     = m_block + 128'(m_nr + 1);
      m_idle_state = m_result;
      m_valid      = 1;
    end else begin
      m_k++;
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (ready) return;
    end
    chk("ready_timeout", {127'd0, ready}, 128'd1);
  endtask

  int           cyc;
  logic [127:0] orig;

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; next = 1'b0; keylen = 1'b0; block = '0;

    fork
      forever begin
        @(posedge clk);
        model_step();
        #2;
        if (reset_n) begin
          chk("ready",        {127'd0, ready},        {127'd0, !m_busy});
          chk("result_valid", {127'd0, result_valid}, {127'd0, m_valid});
          chk("result",       result,                 m_result);
          chk("round_type",   {126'd0, round_type},   {126'd0, exp_round_type()});
          chk("round_nr",     {124'd0, round_nr},     {124'd0, exp_round_nr()});
          chk("dp_state",     dp_state,               exp_dp_state());
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_ready", {127'd0, ready}, 128'd1);
    chk("rst_rtype", {126'd0, round_type}, 128'd3);
    reset_n = 1'b1;
    @(negedge clk);

    // AES-128 directed run
    block = '0; keylen = 1'b0; next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("a128_first_rtype", {126'd0, round_type}, 128'd0);
    chk("a128_first_rnr", {124'd0, round_nr}, 128'd10);
    wait_ready(cyc);
    chk("a128_latency", 128'(cyc), 128'd11);
    chk("a128_result", result, 128'h0B);
    chk("a128_valid", {127'd0, result_valid}, 128'd1);

    // AES-256 directed run, result reaches all-ones
    block = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF0; keylen = 1'b1; next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("a256_first_rnr", {124'd0, round_nr}, 128'd14);
    wait_ready(cyc);
    chk("a256_latency", 128'(cyc), 128'd15);
    chk("a256_result", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);

    // Busy protection: a start mid-run must be ignored
    orig = {$urandom, $urandom, $urandom, $urandom};
    block = orig; keylen = 1'b0; next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (4) @(negedge clk);
    block = 128'h1234; keylen = 1'b1; next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    wait_ready(cyc);
    chk("busy_latency", 128'(cyc + 5), 128'd11);
    chk("busy_result", result, orig + 128'd11);

    // Back-to-back with next held high
    block = 128'h100; keylen = 1'b0; next = 1'b1;
    @(negedge clk);
    block = 128'h200;
    wait_ready(cyc);
    chk("b2b_first", result, 128'h10B);
    @(negedge clk);
    next = 1'b0;
    chk("b2b_valid_drop", {127'd0, result_valid}, 128'd0);
    wait_ready(cyc);
    chk("b2b_second", result, 128'h20B);

    // Reset in the middle of MAIN
    block = 128'hABCD; keylen = 1'b0; next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (round_nr == 4'd5) break;
      @(negedge clk);
    end
    chk("mid_rnr_before", {124'd0, round_nr}, 128'd5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {127'd0, ready}, 128'd1);
    chk("mid_rst_valid", {127'd0, result_valid}, 128'd0);
    chk("mid_rst_rtype", {126'd0, round_type}, 128'd3);
    chk("mid_rst_rnr", {124'd0, round_nr}, 128'd0);
    chk("mid_rst_dp", dp_state, 128'd0);
    chk("mid_rst_result", result, 128'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomised traffic checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      next   = ($urandom_range(0, 3) == 0);
      keylen = 1'($urandom);
      if ($urandom_range(0, 7) == 0)
        block = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, $urandom_range(0, 31) | 32'hFFFF_FFE0};
      else
        block = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    next = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
